// File: rtl/clock_pkg.sv
// Shared constants and types for the multiplexed clock display.
package clock_pkg;

  localparam int unsigned FIELD_W    = 6;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned IDX_W      = 3;

  localparam logic [FIELD_W-1:0] SEC_MAX  = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [FIELD_W-1:0] HOUR_MAX = 6'd23;

  // Active-low {dp,g,f,e,d,c,b,a}, dp off.
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'hBF;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  localparam logic [NUM_DIGITS-1:0] SEL_NONE = 6'h3F;
  localparam logic [IDX_W-1:0]      IDX_LAST = 3'd5;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    logic             oor;
  } bcd_field_t;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_W-1:0] d);
    seg_encode = (d > 4'd9) ? SEG_DASH : SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/clock_bin2bcd.sv
// Splits a 6-bit time field into BCD tens/ones and flags values above the limit.
module clock_bin2bcd
  import clock_pkg::*;
(
  input  logic [FIELD_W-1:0] i_value,
  input  logic [FIELD_W-1:0] i_limit,
  output bcd_field_t         o_bcd_c
);

  always_comb begin
    o_bcd_c      = '0;
    o_bcd_c.tens = BCD_W'(i_value / FIELD_W'(10));
    o_bcd_c.ones = BCD_W'(i_value % FIELD_W'(10));
    o_bcd_c.oor  = (i_value > i_limit);
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit HH:MM:SS seven-segment scanner with per-frame snapshot.
// Optional set-mode field blinking is enabled by defining CLOCK_DISP_BLINK_EN.
module clock_display_scan
  import clock_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [FIELD_W-1:0]    i_count_h,
  input  logic [FIELD_W-1:0]    i_count_m,
  input  logic [FIELD_W-1:0]    i_count_s,
  input  logic                  i_set,
  input  logic                  i_hour,
  input  logic                  i_min,
  input  logic                  i_sec,
  output logic [NUM_DIGITS-1:0] o_digit_sel,
  output logic [SEG_W-1:0]      o_seg
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FIELD_W-1:0]    snap_h_q, snap_h_d;
  logic [FIELD_W-1:0]    snap_m_q, snap_m_d;
  logic [FIELD_W-1:0]    snap_s_q, snap_s_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  scan_tick;
  logic                  field_blank;

  bcd_field_t bcd_h, bcd_m, bcd_s, field;
  logic [BCD_W-1:0] digit;

  clock_bin2bcd u_bcd_s (.i_value(snap_s_q), .i_limit(SEC_MAX),  .o_bcd_c(bcd_s));
  clock_bin2bcd u_bcd_m (.i_value(snap_m_q), .i_limit(MIN_MAX),  .o_bcd_c(bcd_m));
  clock_bin2bcd u_bcd_h (.i_value(snap_h_q), .i_limit(HOUR_MAX), .o_bcd_c(bcd_h));

  // Scan counter, digit index and frame snapshot taken when the index wraps.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    snap_h_d   = snap_h_q;
    snap_m_d   = snap_m_q;
    snap_s_d   = snap_s_q;
    scan_tick  = (scan_cnt_q == SCAN_LAST);
    if (scan_tick) begin
      scan_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d    = '0;
        snap_h_d = i_count_h;
        snap_m_d = i_count_m;
        snap_s_d = i_count_s;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

`ifdef CLOCK_DISP_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;

  // Blink phase runs only in set mode; leaving set mode restarts it visible.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_off_d = blink_off_q;
    if (!i_set) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  always_comb begin
    field_blank = 1'b0;
    if (i_set && blink_off_q) begin
      case (idx_q)
        3'd0, 3'd1: field_blank = i_sec;
        3'd2, 3'd3: field_blank = i_min;
        3'd4, 3'd5: field_blank = i_hour;
        default:    field_blank = 1'b0;
      endcase
    end
  end
`else
  logic unused_blink_inputs;
  assign unused_blink_inputs = &{1'b0, i_set, i_hour, i_min, i_sec};
  assign field_blank = 1'b0;
`endif

  // Segment and enable pattern for the digit currently indexed.
  always_comb begin
    case (idx_q)
      3'd2, 3'd3: field = bcd_m;
      3'd4, 3'd5: field = bcd_h;
      default:    field = bcd_s;
    endcase
    digit       = idx_q[0] ? field.tens : field.ones;
    seg_d       = field.oor ? SEG_DASH : seg_encode(digit);
    if (idx_q == 3'd2 || idx_q == 3'd4) begin
      seg_d[SEG_W-1] = 1'b0;
    end
    if (field_blank) begin
      seg_d = SEG_BLANK;
    end
    digit_sel_d = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      snap_h_q    <= '0;
      snap_m_q    <= '0;
      snap_s_q    <= '0;
      digit_sel_q <= SEL_NONE;
      seg_q       <= SEG_BLANK;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      snap_h_q    <= snap_h_d;
      snap_m_q    <= snap_m_d;
      snap_s_q    <= snap_s_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign o_digit_sel = digit_sel_q;
  assign o_seg       = seg_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: frame-level model checked every cycle plus literal expectations.
module tb_clock_display_scan;

  localparam int SD    = 4;
  localparam int BD    = 16;
  localparam int FRAME = 6 * SD;

  logic       clk;
  logic       rst_n;
  logic [5:0] cnt_h, cnt_m, cnt_s;
  logic       set_mode, sel_h, sel_m, sel_s;
  logic [5:0] dsel;
  logic [7:0] seg;

  int total = 0;
  int bad   = 0;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_count_h  (cnt_h),
    .i_count_m  (cnt_m),
    .i_count_s  (cnt_s),
    .i_set      (set_mode),
    .i_hour     (sel_h),
    .i_min      (sel_m),
    .i_sec      (sel_s),
    .o_digit_sel(dsel),
    .o_seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Expected segments for digit slot k of a frame holding h:m:s.
  function automatic logic [7:0] exp_seg_f(input int k, input int h, input int m,
                                           input int s, input bit blank);
    int v, lim, d;
    logic [7:0] r;
    if (blank) return 8'hFF;
    v   = (k < 2) ? s : (k < 4) ? m : h;
    lim = (k < 4) ? 59 : 23;
    if (v > lim) r = 8'hBF;
    else begin
      d = (k % 2 == 0) ? v % 10 : v / 10;
      r = segtab[d];
    end
    if (k == 2 || k == 4) r[7] = 1'b0;
    return r;
  endfunction

  // Model: n = clock edges since reset release, j = consecutive edges in set mode.
  int n_m = 0;
  int j_m = 0;
  int snap_h = 0, snap_m = 0, snap_s = 0;
  logic [5:0] exp_sel = 6'h3F;
  logic [7:0] exp_seg = 8'hFF;

  always @(posedge clk or negedge rst_n) begin
    int k;
    bit bl;
    if (!rst_n) begin
      n_m = 0; j_m = 0;
      snap_h = 0; snap_m = 0; snap_s = 0;
      exp_sel = 6'h3F;
      exp_seg = 8'hFF;
    end else begin
      n_m++;
      j_m = set_mode ? j_m + 1 : 0;
      k   = ((n_m - 1) / SD) % 6;
      bl  = 1'b0;
`ifdef CLOCK_DISP_BLINK_EN
      if (set_mode && (((j_m - 1) / BD) % 2 == 1))
        bl = (k < 2) ? sel_s : (k < 4) ? sel_m : sel_h;
`endif
      exp_sel = 6'h3F & ~(6'(1) << k);
      exp_seg = exp_seg_f(k, snap_h, snap_m, snap_s, bl);
      if (n_m % FRAME == 0) begin
        snap_h = int'(cnt_h); snap_m = int'(cnt_m); snap_s = int'(cnt_s);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    total++;
    if (dsel !== exp_sel || seg !== exp_seg) begin
      bad++;
      $display("FAIL cycle n=%0d: sel=%h seg=%h, want sel=%h seg=%h",
               n_m, dsel, seg, exp_sel, exp_seg);
    end
  end

  task automatic chk(input string nm, input logic [5:0] es, input logic [7:0] eg);
    total++;
    if (dsel !== es || seg !== eg) begin
      bad++;
      $display("FAIL %s: sel=%h seg=%h, want sel=%h seg=%h", nm, dsel, seg, es, eg);
    end
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (n_m < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n_m < target) begin
      total++;
      bad++;
      $display("FAIL run_to: reached n=%0d, want n=%0d", n_m, target);
    end
  endtask

  logic [5:0] scan_sel [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [7:0] scan_seg [6] = '{8'h82, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9};
  logic [7:0] oor_seg  [6] = '{8'hBF, 8'hBF, 8'h19, 8'hB0, 8'h3F, 8'hBF};

  initial begin
    rst_n = 1'b0;
    cnt_h = 6'd12; cnt_m = 6'd34; cnt_s = 6'd56;
    set_mode = 1'b0; sel_h = 1'b0; sel_m = 1'b0; sel_s = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("reset", 6'h3F, 8'hFF);
    rst_n = 1'b1;

    run_to(1);  #1 chk("first_after_reset", 6'h3E, 8'hC0);

    // Second frame shows 12:34:56.
    for (int i = 0; i < 6; i++) begin
      run_to(FRAME + 1 + SD * i);
      #1 chk($sformatf("scan_idx%0d", i), scan_sel[i], scan_seg[i]);
    end

    // Mid-frame change of seconds only reaches the next frame.
    run_to(49); #1 chk("snap_cur_ones", 6'h3E, 8'h82);
    cnt_s = 6'd57;
    run_to(53); #1 chk("snap_cur_tens", 6'h3D, 8'h92);
    run_to(73); #1 chk("snap_next_ones", 6'h3E, 8'hF8);
    run_to(77); #1 chk("snap_next_tens", 6'h3D, 8'h92);

    // Out-of-range seconds and hours show dashes.
    cnt_s = 6'd63; cnt_h = 6'd24;
    for (int i = 0; i < 6; i++) begin
      run_to(97 + SD * i);
      #1 chk($sformatf("oor_idx%0d", i), scan_sel[i], oor_seg[i]);
    end

    // Set mode with minutes selected.
    run_to(120);
    set_mode = 1'b1; sel_m = 1'b1;
    run_to(133); #1 chk("blink_visible", 6'h37, 8'hB0);
`ifdef CLOCK_DISP_BLINK_EN
    run_to(177); #1 chk("blink_min_ones", 6'h3B, 8'hFF);
    run_to(181); #1 chk("blink_min_tens", 6'h37, 8'hFF);
    sel_h = 1'b1; sel_s = 1'b1;
    run_to(209); #1 chk("blink_multi_hour", 6'h2F, 8'hFF);
`else
    run_to(177); #1 chk("noblink_min_ones", 6'h3B, 8'h19);
    run_to(181); #1 chk("noblink_min_tens", 6'h37, 8'hB0);
    sel_h = 1'b1; sel_s = 1'b1;
    run_to(209); #1 chk("noblink_multi_hour", 6'h2F, 8'h3F);
`endif
    run_to(216);
    set_mode = 1'b0;
    run_to(225); #1 chk("set_off_visible", 6'h3B, 8'h19);

    // Reset in the middle of index 3.
    run_to(230);
    rst_n = 1'b0;
    #1 chk("reset_mid_frame", 6'h3F, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_to(1);  #1 chk("restart_idx0", 6'h3E, 8'hC0);
    run_to(4);  #1 chk("restart_idx0_hold", 6'h3E, 8'hC0);
    run_to(5);  #1 chk("restart_idx1", 6'h3D, 8'hC0);
    run_to(9);  #1 chk("restart_idx2", 6'h3B, 8'h40);
    run_to(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
